sfifo_stream_rd: RTL and testbench

Read-side adapter for the synchronous FIFO (`sfifo`). It drains the FIFO read port, which has a fixed 1-cycle read latency, and presents the data as a valid/ready stream. A 2-entry output buffer and in-flight credit tracking sustain one word per cycle without overreading. It sits between an `sfifo` instance and any stream consumer, and is the counterpart of the producer logic that drives `fifo_we`/`fifo_wd`.

---
 rtl/svlib_sfifo_pkg.sv | 24 ++
 rtl/sfifo_rd_buf2.sv | 73 +++++++
 rtl/sfifo_stream_rd.sv | 92 +++++++++
 tb/tb_sfifo_stream_rd.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/svlib_sfifo_pkg.sv
// Shared types for the sfifo read-side stream adapter, plus a drop-in instantiation macro.
// Optional statistics are enabled by defining SFIFO_STREAM_RD_STAT_EN.
package svlib_sfifo_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } buf_st_e;

  localparam int unsigned STAT_W = 32;

  function automatic logic [1:0] buf_occ(input buf_st_e st);
    case (st)
      ONE:     return 2'd1;
      TWO:     return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// Placed next to sfifo_inst; connects by name to the FIFO instance's signals.
`define SFIFO_STREAM_RD_INST(name) sfifo_stream_rd #(.DW(DW)) name (.*);

// File: rtl/sfifo_rd_buf2.sv
// Two-entry, order-preserving output store for the sfifo stream adapter.
// Head is always the word presented downstream; tail only holds data in state TWO.
module sfifo_rd_buf2
  import svlib_sfifo_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          i_clr,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_wdata,
  output logic          o_valid,
  output logic [DW-1:0] o_data,
  output buf_st_e       o_state
);

  buf_st_e       r_state;
  buf_st_e       w_state_nxt;
  logic [DW-1:0] r_head;
  logic [DW-1:0] r_tail;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      EMPTY: if (i_push) w_state_nxt = ONE;
      ONE: begin
        if (i_push && !i_pop)      w_state_nxt = TWO;
        else if (!i_push && i_pop) w_state_nxt = EMPTY;
      end
      TWO:     if (i_pop && !i_push) w_state_nxt = ONE;
      default: w_state_nxt = EMPTY;
    endcase
    // Clear wins over any same-cycle push; a same-cycle pop was still a legal transfer.
    if (i_clr) w_state_nxt = EMPTY;
  end

  always_comb begin
    o_valid = (r_state != EMPTY);
    o_data  = r_head;
    o_state = r_state;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_head <= '0;
      r_tail <= '0;
    end else if (!i_clr) begin
      case (r_state)
        EMPTY: if (i_push) r_head <= i_wdata;
        ONE: begin
          if (i_push && i_pop) r_head <= i_wdata;
          else if (i_push)     r_tail <= i_wdata;
        end
        TWO: begin
          if (i_pop)  r_head <= r_tail;
          if (i_push) r_tail <= i_wdata;
        end
        default: ;
      endcase
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(r_state == TWO && i_push && !i_pop && !i_clr));

endmodule

// File: rtl/sfifo_stream_rd.sv
// Read-side adapter: drains a 1-cycle-latency sfifo read port into a valid/ready stream.
// Define SFIFO_STREAM_RD_STAT_EN to add the stat_words / stat_stall counters.
module sfifo_stream_rd
  import svlib_sfifo_pkg::*;
#(
  parameter int unsigned DW = 16
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          flush,
  input  logic          fifo_empty,
  input  logic [DW-1:0] fifo_rd,
  output logic          fifo_re,
  output logic          fifo_fsh,
  output logic          m_valid,
  output logic [DW-1:0] m_data,
  input  logic          m_ready
`ifdef SFIFO_STREAM_RD_STAT_EN
  ,
  output logic [STAT_W-1:0] stat_words,
  output logic [STAT_W-1:0] stat_stall
`endif
);

  // Stream handshake: a word moves when m_valid and m_ready are both high at a rising
  // edge; once m_valid is high, m_data holds and m_valid stays high until that transfer.

  logic       r_inf;
  logic       r_drop;
  logic       w_pop;
  logic       w_push;
  buf_st_e    w_state;
  logic [1:0] w_occ;
  logic [2:0] w_committed;
  logic [2:0] w_limit;

  assign w_pop  = m_valid & m_ready;
  assign w_push = r_inf & ~r_drop;
  assign w_occ  = buf_occ(w_state);

  // Issue only if buffered plus in-flight words, less this cycle's pop, leave a free slot.
  assign w_committed = {1'b0, w_occ} + {2'b00, r_inf};
  assign w_limit     = 3'd2 + {2'b00, w_pop};
  assign fifo_re     = ~fifo_empty & ~flush & (w_committed < w_limit);
  assign fifo_fsh    = flush;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_inf  <= 1'b0;
      r_drop <= 1'b0;
    end else begin
      r_inf  <= fifo_re;
      r_drop <= flush & r_inf;
    end
  end

  sfifo_rd_buf2 #(.DW(DW)) u_buf (
    .clk     (clk),
    .rstn    (rstn),
    .i_clr   (flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (fifo_rd),
    .o_valid (m_valid),
    .o_data  (m_data),
    .o_state (w_state)
  );

`ifdef SFIFO_STREAM_RD_STAT_EN
  logic [STAT_W-1:0] r_stat_words;
  logic [STAT_W-1:0] r_stat_stall;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stat_words <= '0;
      r_stat_stall <= '0;
    end else if (flush) begin
      r_stat_words <= '0;
      r_stat_stall <= '0;
    end else begin
      if (w_pop)              r_stat_words <= r_stat_words + 1'b1;
      if (m_valid && !m_ready) r_stat_stall <= r_stat_stall + 1'b1;
    end
  end

  assign stat_words = r_stat_words;
  assign stat_stall = r_stat_stall;
`else
  // Statistics compiled out; the stream path is identical either way.
`endif

endmodule

// File: tb/tb_sfifo_stream_rd.sv
// Self-checking bench for sfifo_stream_rd against a queue-based FIFO and stream reference.
// Define SFIFO_STREAM_RD_STAT_EN to also exercise the statistics counters.
module tb_sfifo_stream_rd;

  localparam int DW = 16;

  logic          clk;
  logic          rstn;
  logic          flush;
  logic          fifo_empty;
  logic [DW-1:0] fifo_rd;
  logic          fifo_re;
  logic          fifo_fsh;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
`ifdef SFIFO_STREAM_RD_STAT_EN
  logic [31:0]   stat_words;
  logic [31:0]   stat_stall;
`endif

  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] mdl_q[$];
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] got_q[$];
  int            got_cyc[$];
  int            re_cyc[$];
  int            cyc = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  sfifo_stream_rd #(.DW(DW)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .fifo_empty (fifo_empty),
    .fifo_rd    (fifo_rd),
    .fifo_re    (fifo_re),
    .fifo_fsh   (fifo_fsh),
    .m_valid    (m_valid),
    .m_data     (m_data),
    .m_ready    (m_ready)
`ifdef SFIFO_STREAM_RD_STAT_EN
    ,
    .stat_words (stat_words),
    .stat_stall (stat_stall)
`endif
  );

  // Clock and watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  // Behavioural sfifo: 1-cycle read latency, flush empties it, shares rstn.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mdl_q.delete();
      fifo_rd    <= '0;
      fifo_empty <= 1'b1;
    end else begin
      if (fifo_fsh) mdl_q.delete();
      else if (fifo_re && mdl_q.size() > 0) fifo_rd <= mdl_q.pop_front();
      if (wr_en) mdl_q.push_back(wr_data);
      fifo_empty <= (mdl_q.size() == 0);
    end
  end

  // Transaction log sampled mid-cycle
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (rstn) begin
      if (fifo_re) re_cyc.push_back(cyc);
      if (m_valid && m_ready) begin
        got_q.push_back(m_data);
        got_cyc.push_back(cyc);
      end
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_logs();
    got_q.delete();
    got_cyc.delete();
    re_cyc.delete();
    exp_q.delete();
  endtask

  task automatic write_word(input logic [DW-1:0] w);
    wr_en   = 1'b1;
    wr_data = w;
    exp_q.push_back(w);
    tick();
    wr_en   = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    rstn = 1'b1;
    #1 rstn = 1'b0;
    #3;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_re: got %b expected 0", fifo_re); end
    n_checks++; if (fifo_fsh !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_fsh: got %b expected 0", fifo_fsh); end
    n_checks++; if (m_data !== 16'h0000) begin n_fail++; $display("FAIL reset_m_data: got %h expected 0000", m_data); end
    tick();
    tick();
    rstn = 1'b1;
    tick();
  endtask

  task automatic test_streaming();
    int lat;
    int span;
    logic [DW-1:0] g;
    clear_logs();
    m_ready = 1'b1;
    for (int i = 1; i <= 6; i++) write_word(DW'(i));
    repeat (10) tick();
    n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL stream_count: got %0d expected 6", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL stream_data[%0d]: got %h expected %h", i, g, exp_q[i]); end
    end
    lat = -1;
    if (re_cyc.size() > 0 && got_cyc.size() > 0) lat = got_cyc[0] - re_cyc[0];
    n_checks++; if (lat !== 2) begin n_fail++; $display("FAIL stream_latency: got %0d expected 2", lat); end
    span = -1;
    if (got_cyc.size() >= 6) span = got_cyc[5] - got_cyc[0];
    n_checks++; if (span !== 5) begin n_fail++; $display("FAIL stream_gapless: got %0d expected 5", span); end
    n_checks++; if (re_cyc.size() !== 6) begin n_fail++; $display("FAIL stream_reads: got %0d expected 6", re_cyc.size()); end
  endtask

  task automatic test_backpressure();
    int span;
    logic [DW-1:0] g;
    clear_logs();
    m_ready = 1'b0;
    for (int i = 1; i <= 6; i++) write_word(DW'(i));
    for (int i = 0; i < 10; i++) begin
      n_checks++;
      if ({m_valid, m_data} !== {1'b1, 16'h0001}) begin
        n_fail++; $display("FAIL bp_hold[%0d]: got valid=%b data=%h expected valid=1 data=0001", i, m_valid, m_data);
      end
      tick();
    end
    n_checks++; if (re_cyc.size() !== 2) begin n_fail++; $display("FAIL bp_reads: got %0d expected 2", re_cyc.size()); end
    m_ready = 1'b1;
    repeat (12) tick();
    n_checks++; if (got_q.size() !== 6) begin n_fail++; $display("FAIL bp_count: got %0d expected 6", got_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL bp_data[%0d]: got %h expected %h", i, g, exp_q[i]); end
    end
    span = -1;
    if (got_cyc.size() >= 6) span = got_cyc[5] - got_cyc[0];
    n_checks++; if (span !== 5) begin n_fail++; $display("FAIL bp_gapless: got %0d expected 5", span); end
  endtask

  task automatic test_empty_boundary();
    logic [DW-1:0] g;
    clear_logs();
    m_ready = 1'b1;
    write_word(16'h00AA);
    repeat (8) tick();
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL empty_count: got %0d expected 1", got_q.size()); end
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++; if (g !== 16'h00AA) begin n_fail++; $display("FAIL empty_data: got %h expected 00aa", g); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL empty_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL empty_fifo_re: got %b expected 0", fifo_re); end
    n_checks++; if (re_cyc.size() !== 1) begin n_fail++; $display("FAIL empty_reads: got %0d expected 1", re_cyc.size()); end
  endtask

  task automatic test_flush();
    logic found;
    logic [DW-1:0] g;
    clear_logs();
    m_ready = 1'b1;
    write_word(16'h0011);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (fifo_re) found = 1'b1;
      else tick();
    end
    n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL flush_issue: got %b expected 1", found); end
    tick();
    flush = 1'b1;
    #1;
    n_checks++; if (fifo_fsh !== 1'b1) begin n_fail++; $display("FAIL flush_fsh_on: got %b expected 1", fifo_fsh); end
    n_checks++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL flush_no_read: got %b expected 0", fifo_re); end
    exp_q.delete();
    tick();
    flush = 1'b0;
    #1;
    n_checks++; if (fifo_fsh !== 1'b0) begin n_fail++; $display("FAIL flush_fsh_off: got %b expected 0", fifo_fsh); end
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_dropped: got %b expected 0", m_valid); end
    tick();
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL flush_still_empty: got %b expected 0", m_valid); end
    write_word(16'h0033);
    repeat (8) tick();
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL flush_count: got %0d expected 1", got_q.size()); end
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++; if (g !== 16'h0033) begin n_fail++; $display("FAIL flush_next_word: got %h expected 0033", g); end
  endtask

  task automatic test_random();
    int issued;
    int delivered;
    logic prev_stall;
    logic [DW-1:0] prev_data;
    logic [DW-1:0] g;
    clear_logs();
    issued = 0;
    delivered = 0;
    prev_stall = 1'b0;
    prev_data = '0;
    for (int c = 0; c < 400; c++) begin
      wr_en   = ($urandom_range(0, 99) < 45);
      wr_data = DW'($urandom_range(0, 65535));
      if (wr_en) exp_q.push_back(wr_data);
      m_ready = ($urandom_range(0, 99) < 65);
      #1;
      if (fifo_re) issued++;
      if (m_valid && m_ready) delivered++;
      n_checks++; if ((fifo_re & fifo_empty) !== 1'b0) begin n_fail++; $display("FAIL rnd_read_empty[%0d]: got 1 expected 0", c); end
      n_checks++; if (issued - delivered > 2) begin n_fail++; $display("FAIL rnd_outstanding[%0d]: got %0d expected <=2", c, issued - delivered); end
      if (prev_stall) begin
        n_checks++;
        if ({m_valid, m_data} !== {1'b1, prev_data}) begin
          n_fail++; $display("FAIL rnd_hold[%0d]: got valid=%b data=%h expected valid=1 data=%h", c, m_valid, m_data, prev_data);
        end
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      tick();
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    repeat (60) tick();
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL rnd_count: got %0d expected %0d", got_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 'x;
      n_checks++; if (g !== exp_q[i]) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h expected %h", i, g, exp_q[i]); end
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] g;
    clear_logs();
    m_ready = 1'b0;
    for (int i = 1; i <= 4; i++) write_word(DW'(16'h0050 + i));
    repeat (6) tick();
    n_checks++; if ({m_valid, m_data} !== {1'b1, 16'h0051}) begin n_fail++; $display("FAIL rstmid_pre: got valid=%b data=%h expected valid=1 data=0051", m_valid, m_data); end
    #2;
    rstn = 1'b0;
    #1;
    n_checks++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_valid: got %b expected 0", m_valid); end
    n_checks++; if (fifo_re !== 1'b0) begin n_fail++; $display("FAIL rstmid_fifo_re: got %b expected 0", fifo_re); end
    n_checks++; if (m_data !== 16'h0000) begin n_fail++; $display("FAIL rstmid_m_data: got %h expected 0000", m_data); end
    tick();
    rstn = 1'b1;
    clear_logs();
    m_ready = 1'b1;
    repeat (6) tick();
    n_checks++; if (got_q.size() !== 0) begin n_fail++; $display("FAIL rstmid_stale: got %0d words expected 0", got_q.size()); end
    write_word(16'h0077);
    repeat (8) tick();
    n_checks++; if (got_q.size() !== 1) begin n_fail++; $display("FAIL rstmid_count: got %0d expected 1", got_q.size()); end
    g = (got_q.size() > 0) ? got_q[0] : 'x;
    n_checks++; if (g !== 16'h0077) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0077", g); end
  endtask

`ifdef SFIFO_STREAM_RD_STAT_EN
  task automatic test_stats();
    int stalls_left;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    clear_logs();
    stalls_left = 3;
    for (int c = 0; c < 40; c++) begin
      wr_en   = (c < 6);
      wr_data = DW'(c + 1);
      if (wr_en) exp_q.push_back(wr_data);
      if (m_valid && stalls_left > 0) begin
        m_ready = 1'b0;
        stalls_left--;
      end else begin
        m_ready = 1'b1;
      end
      tick();
    end
    wr_en = 1'b0;
    m_ready = 1'b1;
    n_checks++; if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL stat_xfers: got %0d expected %0d", got_q.size(), exp_q.size()); end
    n_checks++; if (stat_words !== 32'd6) begin n_fail++; $display("FAIL stat_words: got %0d expected 6", stat_words); end
    n_checks++; if (stat_stall !== 32'd3) begin n_fail++; $display("FAIL stat_stall: got %0d expected 3", stat_stall); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    n_checks++; if (stat_words !== 32'd0) begin n_fail++; $display("FAIL stat_words_clr: got %0d expected 0", stat_words); end
    n_checks++; if (stat_stall !== 32'd0) begin n_fail++; $display("FAIL stat_stall_clr: got %0d expected 0", stat_stall); end
  endtask
`endif

  // Sequence and report
  initial begin
    rstn    = 1'b1;
    flush   = 1'b0;
    m_ready = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_empty_boundary();
    test_flush();
    test_random();
    test_reset_mid();
`ifdef SFIFO_STREAM_RD_STAT_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
